mem_access_unit: RTL and testbench

//  Executes the 4-bit ramMode command {funct3, we} issued by the decoder for RV32I loads/stores.

---
 rtl/mem_access_unit_pkg.sv | 39 +++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store memory access unit.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  // ram_mode = {funct3, we}
  localparam int unsigned RM_WE    = 0;
  localparam int unsigned RM_F3_LO = 1;
  localparam int unsigned RM_F3_HI = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_GAP0,
    S_BEAT1,
    S_GAP1,
    S_DONE
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and data-memory bus signals of the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic [3:0]  ram_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, ram_mode, addr, wdata, bus_ack, bus_rdata,
    output busy, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, ram_mode, addr, wdata, bus_ack, bus_rdata,
    input  busy, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and merge/shift/extend for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] st_wide;
  logic [31:0] ld_word;

  assign shamt   = {offset, 3'b000};
  assign be_wide = {4'b0000, size_mask(funct3[1:0])} << offset;
  assign st_wide = {32'h0, wdata} << shamt;
  assign ld_word = 32'({data1, data0} >> shamt);

  assign be0    = be_wide[3:0];
  assign be1    = be_wide[7:4];
  assign wdata0 = st_wide[31:0];
  assign wdata1 = st_wide[63:32];
  assign split  = |be_wide[7:4];

  // Sign- or zero-extend the aligned load value; funct3[2] selects unsigned.
  always_comb begin
    load_data = ld_word;
    case (funct3[1:0])
      SZ_B:    load_data = {{24{ld_word[7] & ~funct3[2]}}, ld_word[7:0]};
      SZ_H:    load_data = {{16{ld_word[15] & ~funct3[2]}}, ld_word[15:0]};
      default: load_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store access unit: request latch, beat FSM, timeout, registered outputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT          = 255,
  parameter int unsigned CNT_W            = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_access_unit_if.master io
);

  state_t state_q, state_d;

  logic [3:0]       mode_q;
  logic [31:0]      addr_q, wdata_q, data0_q, data1_q;
  logic [CNT_W-1:0] cnt_q;

  logic        busy_q, done_q, err_q, bus_req_q, bus_we_q;
  logic [31:0] rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;

  logic        busy_d, done_d, err_d, bus_req_d, bus_we_d;
  logic [31:0] rdata_d, bus_addr_d, bus_wdata_d;
  logic [3:0]  bus_be_d;

  // In IDLE the request is latched on the same edge that launches BEAT0,
  // so the beat-0 bus values must come from the live inputs there.
  logic [3:0]  cur_mode;
  logic [31:0] cur_addr, cur_wdata, word_addr;
  logic [2:0]  funct3;
  logic        we;

  assign cur_mode  = (state_q == S_IDLE) ? io.ram_mode : mode_q;
  assign cur_addr  = (state_q == S_IDLE) ? io.addr     : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? io.wdata    : wdata_q;
  assign funct3    = cur_mode[RM_F3_HI:RM_F3_LO];
  assign we        = cur_mode[RM_WE];
  assign word_addr = {cur_addr[31:2], 2'b00};

  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, load_data;
  logic        split;

  mem_lane_align u_align (
    .funct3    (funct3),
    .offset    (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .data0     (data0_q),
    .data1     (data1_q),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .split     (split),
    .load_data (load_data)
  );

  logic in_beat, acked, timed_out, bad_req;

  assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign acked     = in_beat && bus_req_q && io.bus_ack;
  assign timed_out = in_beat && !io.bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign bad_req   = !funct3_legal(funct3) || (split && !SPLIT_MISALIGNED);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (io.req_valid) state_d = bad_req ? S_DONE : S_BEAT0;
      S_BEAT0: if (acked) state_d = S_GAP0; else if (timed_out) state_d = S_DONE;
      S_GAP0:  state_d = split ? S_BEAT1 : S_DONE;
      S_BEAT1: if (acked) state_d = S_GAP1; else if (timed_out) state_d = S_DONE;
      S_GAP1:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next output values, registered below; bus fields load on beat entry and hold otherwise.
  always_comb begin
    busy_d      = (state_d == S_BEAT0) || (state_d == S_GAP0) ||
                  (state_d == S_BEAT1) || (state_d == S_GAP1);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_DONE) && ((state_q == S_IDLE) || timed_out);
    rdata_d     = '0;
    bus_req_d   = (state_d == S_BEAT0) || (state_d == S_BEAT1);
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    if ((state_d == S_DONE) && ((state_q == S_GAP0) || (state_q == S_GAP1)) && !we)
      rdata_d = load_data;
    if ((state_d == S_BEAT0) && (state_q != S_BEAT0)) begin
      bus_we_d    = we;
      bus_addr_d  = word_addr;
      bus_be_d    = be0;
      bus_wdata_d = wdata0;
    end else if ((state_d == S_BEAT1) && (state_q != S_BEAT1)) begin
      bus_we_d    = we;
      bus_addr_d  = word_addr + 32'd4;
      bus_be_d    = be1;
      bus_wdata_d = wdata1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Request latch, per-beat read capture and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      cnt_q   <= '0;
    end else begin
      if ((state_q == S_IDLE) && io.req_valid) begin
        mode_q  <= io.ram_mode;
        addr_q  <= io.addr;
        wdata_q <= io.wdata;
      end
      if (acked && (state_q == S_BEAT0)) data0_q <= io.bus_rdata;
      if (acked && (state_q == S_BEAT1)) data1_q <= io.bus_rdata;
      if (bus_req_d && (state_d != state_q)) cnt_q <= '0;
      else if (in_beat && !io.bus_ack)       cnt_q <= cnt_q + 1'b1;
    end
  end

  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.err       = err_q;
  assign io.rdata     = rdata_q;
  assign io.bus_req   = bus_req_q;
  assign io.bus_we    = bus_we_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_be    = bus_be_q;
  assign io.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-level memory/reference model, directed and random accesses.
module tb_mem_access_unit;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  ram_mode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_access_unit_if io_a ();
  mem_access_unit_if io_b ();

  mem_access_unit #(.SPLIT_MISALIGNED(1'b1), .TIMEOUT(T), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .io(io_a));
  mem_access_unit #(.SPLIT_MISALIGNED(1'b0), .TIMEOUT(T), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .io(io_b));

  assign io_a.req_valid = req_valid & ~sel;
  assign io_b.req_valid = req_valid & sel;
  assign io_a.ram_mode  = ram_mode;
  assign io_b.ram_mode  = ram_mode;
  assign io_a.addr      = addr;
  assign io_b.addr      = addr;
  assign io_a.wdata     = wdata;
  assign io_b.wdata     = wdata;
  assign io_a.bus_ack   = bus_ack;
  assign io_b.bus_ack   = bus_ack;
  assign io_a.bus_rdata = bus_rdata;
  assign io_b.bus_rdata = bus_rdata;

  logic        o_busy, o_done, o_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;

  assign o_busy      = sel ? io_b.busy      : io_a.busy;
  assign o_done      = sel ? io_b.done      : io_a.done;
  assign o_err       = sel ? io_b.err       : io_a.err;
  assign o_rdata     = sel ? io_b.rdata     : io_a.rdata;
  assign o_bus_req   = sel ? io_b.bus_req   : io_a.bus_req;
  assign o_bus_we    = sel ? io_b.bus_we    : io_a.bus_we;
  assign o_bus_addr  = sel ? io_b.bus_addr  : io_a.bus_addr;
  assign o_bus_be    = sel ? io_b.bus_be    : io_a.bus_be;
  assign o_bus_wdata = sel ? io_b.bus_wdata : io_a.bus_wdata;

  int n_pass = 0;
  int n_total = 0;
  int last_cyc;
  logic [31:0] last_rdata;

  bit [7:0] mem [bit [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rdbyte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] rdword(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rdbyte(a + 32'(i));
    return w;
  endfunction

  task automatic setword(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  // One access: s selects the non-splitting instance; d0/d1 = ack delay per beat (>=T never acks).
  task automatic do_access(input bit s, input logic [3:0] mode, input logic [31:0] a,
                           input logic [31:0] wd, input int d0, input int d1);
    logic [2:0]  f3;
    logic        wr, legal, two, bad, exp_err;
    int          size, exp_done, nexp, cyc, nst, wt, k, off, j;
    int          dl [2];
    logic [31:0] exp_ba [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_bw [2];
    logic [31:0] w1, last, b, lv, exp_rd;
    bit          inb, got;

    f3    = mode[3:1];
    wr    = mode[0];
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    last  = a + 32'(size - 1);
    w1    = {last[31:2], 2'b00};
    exp_ba[0] = {a[31:2], 2'b00};
    exp_ba[1] = w1;
    two   = (w1 != exp_ba[0]);
    exp_be[0] = '0;
    exp_be[1] = '0;
    exp_bw[0] = '0;
    exp_bw[1] = '0;
    lv = '0;
    for (int i = 0; i < size; i++) begin
      b = a + 32'(i);
      k = (b[31:2] == a[31:2]) ? 0 : 1;
      exp_be[k][b[1:0]] = 1'b1;
      lv[8*i +: 8] = rdbyte(b);
    end
    for (int L = 0; L < 4; L++) begin
      j = L - off;
      if (j >= 0) exp_bw[0][8*L +: 8] = wd[8*j +: 8];
      j = L + 4 - off;
      if (j < 4) exp_bw[1][8*L +: 8] = wd[8*j +: 8];
    end
    if (!f3[2] && size == 1 && lv[7])  lv[31:8]  = '1;
    if (!f3[2] && size == 2 && lv[15]) lv[31:16] = '1;

    bad = !legal || (two && s);
    if (bad)                         begin exp_err = 1'b1; exp_done = 1;           nexp = 0; end
    else if (d0 >= int'(T))          begin exp_err = 1'b1; exp_done = 1 + T;       nexp = 1; end
    else if (!two)                   begin exp_err = 1'b0; exp_done = 3 + d0;      nexp = 1; end
    else if (d1 >= int'(T))          begin exp_err = 1'b1; exp_done = 3 + d0 + T;  nexp = 2; end
    else                             begin exp_err = 1'b0; exp_done = 5 + d0 + d1; nexp = 2; end
    exp_rd = (exp_err || wr) ? 32'h0 : lv;
    dl[0] = d0;
    dl[1] = d1;

    sel = s;
    req_valid = 1'b1;
    ram_mode = mode;
    addr = a;
    wdata = wd;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ram_mode = 4'($urandom);
    addr = $urandom;
    wdata = $urandom;

    cyc = 1; nst = 0; wt = 0; inb = 0; got = 0;
    while (cyc <= 60 && !got) begin
      if (cyc == 1) chk("busy_first_cycle", 32'(o_busy), 32'(!bad));
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (o_bus_req) begin
        if (!inb) begin
          inb = 1; wt = 0;
          chk("beat_expected", 32'(nst < nexp), 32'd1);
          nst++;
        end
        k = (nst >= 2) ? 1 : 0;
        chk("bus_addr", o_bus_addr, exp_ba[k]);
        chk("bus_be", 32'(o_bus_be), 32'(exp_be[k]));
        chk("bus_we", 32'(o_bus_we), 32'(wr));
        if (wr) chk("bus_wdata", o_bus_wdata, exp_bw[k]);
        if (wt == dl[k]) begin
          bus_ack = 1'b1;
          bus_rdata = rdword(o_bus_addr);
          if (o_bus_we)
            for (int L = 0; L < 4; L++)
              if (o_bus_be[L]) mem[o_bus_addr + 32'(L)] = o_bus_wdata[8*L +: 8];
          inb = 0;
        end else wt++;
      end else if ($urandom_range(0, 3) == 0) begin
        bus_ack = 1'b1;
      end
      if (o_done) begin
        got = 1;
        bus_ack = 1'b0;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        chk("err", 32'(o_err), 32'(exp_err));
        chk("rdata", o_rdata, exp_rd);
        chk("bus_req_at_done", 32'(o_bus_req), 32'd0);
        chk("busy_at_done", 32'(o_busy), 32'd0);
        chk("beats_started", 32'(nst), 32'(nexp));
        last_cyc = cyc;
        last_rdata = o_rdata;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(o_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rf3;
    logic        rwe;
    logic [31:0] ra;
    int          rd0, rd1;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(io_a.busy), 0);
    chk("rst_done", 32'(io_a.done), 0);
    chk("rst_err", 32'(io_a.err), 0);
    chk("rst_rdata", io_a.rdata, 0);
    chk("rst_bus_req", 32'(io_a.bus_req), 0);
    chk("rst_bus_we", 32'(io_a.bus_we), 0);
    chk("rst_bus_addr", io_a.bus_addr, 0);
    chk("rst_bus_be", 32'(io_a.bus_be), 0);
    chk("rst_bus_wdata", io_a.bus_wdata, 0);
    chk("rst_b_busy", 32'(io_b.busy), 0);
    chk("rst_b_bus_req", 32'(io_b.bus_req), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW aligned, immediate ack
    setword(32'h100, 32'hDEADBEEF);
    do_access(1'b0, 4'b0100, 32'h100, 32'h0, 0, 0);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_latency", 32'(last_cyc), 32'd3);

    // LB / LBU at byte offset 3
    setword(32'h100, 32'h80123456);
    do_access(1'b0, 4'b0000, 32'h103, 32'h0, 0, 0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    do_access(1'b0, 4'b1000, 32'h103, 32'h0, 1, 0);
    chk("lbu_rdata", last_rdata, 32'h00000080);

    // Split SW then split LW reads it back
    do_access(1'b0, 4'b0101, 32'h102, 32'hAABBCCDD, 1, 0);
    do_access(1'b0, 4'b0100, 32'h102, 32'h0, 0, 2);
    chk("split_lw_rdata", last_rdata, 32'hAABBCCDD);

    // LH crossing the top of the address space; non-split instance reports err
    do_access(1'b0, 4'b0010, 32'hFFFFFFFF, 32'h0, 0, 0);
    do_access(1'b1, 4'b0010, 32'hFFFFFFFF, 32'h0, 0, 0);
    chk("ns_err", 32'(io_b.err), 32'd0);

    // Illegal funct3
    do_access(1'b0, 4'b0110, 32'h100, 32'h0, 0, 0);

    // Timeout on beat0, and ack on the last permitted cycle
    do_access(1'b0, 4'b0100, 32'h300, 32'h0, 100, 0);
    do_access(1'b0, 4'b0100, 32'h300, 32'h0, T - 1, 0);

    // Split store timing out on beat1 keeps beat0 bytes
    do_access(1'b0, 4'b0011, 32'h3FF, 32'h00001122, 0, 100);
    do_access(1'b0, 4'b1000, 32'h3FF, 32'h0, 0, 0);
    chk("partial_store", last_rdata, 32'h00000022);

    // Reset while BEAT0 is waiting
    sel = 1'b0;
    req_valid = 1'b1;
    ram_mode = 4'b0100;
    addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_bus_req", 32'(o_bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(o_bus_req), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    setword(32'h200, 32'h13572468);
    do_access(1'b0, 4'b0100, 32'h200, 32'h0, 0, 0);
    chk("post_rst_lw", last_rdata, 32'h13572468);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      rwe = rf3[2] ? 1'b0 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1:       ra = 32'h400 + 32'($urandom_range(0, 15));
        default: ra = $urandom;
      endcase
      rd0 = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 3));
      rd1 = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 3) == 0), {rf3, rwe}, ra, $urandom, rd0, rd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
